// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data requesters,
// one transaction in flight, data priority with a bounded streak against a waiting fetch.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  input  logic                dmem_req_i,
  input  logic                dmem_wen_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  input  logic [DATA_W/8-1:0] dmem_wstrb_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  output logic                mem_req_o,
  output logic                mem_wen_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_ready_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam int SW = $clog2(MAX_DSTREAK + 2);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;
  state_t              state_q, state_d;
  logic [SW-1:0]       dstreak_q, dstreak_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                irvalid_q, irvalid_d;
  logic                drvalid_q, drvalid_d;
  logic [DATA_W-1:0]   irdata_q, irdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                idle, fetch_first, done;
  // grants are combinational in IDLE, so reset has to mask them as well
  always_comb begin
    idle        = state_q == IDLE && !rst_i;
    fetch_first = imem_req_i && dstreak_q >= SMAX;
    dmem_gnt_o  = idle && dmem_req_i && !fetch_first;
    imem_gnt_o  = idle && imem_req_i && !dmem_gnt_o;
    done        = state_q != IDLE && mem_ready_i;
    state_d     = dmem_gnt_o ? DBUSY : imem_gnt_o ? IBUSY : done ? IDLE : state_q;
    dstreak_d   = imem_gnt_o ? '0 : !dmem_gnt_o ? dstreak_q : !imem_req_i ? '0 :
                  dstreak_q == SMAX ? dstreak_q : dstreak_q + SW'(1);
    wen_d       = dmem_gnt_o ? dmem_wen_i : imem_gnt_o ? 1'b0 : wen_q;
    addr_d      = dmem_gnt_o ? dmem_addr_i : imem_gnt_o ? imem_addr_i : addr_q;
    wdata_d     = dmem_gnt_o ? dmem_wdata_i : imem_gnt_o ? '0 : wdata_q;
    wstrb_d     = dmem_gnt_o ? dmem_wstrb_i : imem_gnt_o ? '0 : wstrb_q;
    irvalid_d   = done && state_q == IBUSY;
    drvalid_d   = done && state_q == DBUSY;
    irdata_d    = irvalid_d ? mem_rdata_i : irdata_q;
    drdata_d    = drvalid_d ? (wen_q ? '0 : mem_rdata_i) : drdata_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      irvalid_q <= 1'b0;
      drvalid_q <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      irvalid_q <= irvalid_d;
      drvalid_q <= drvalid_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
    end
  end
  assign mem_req_o     = state_q != IDLE;
  assign mem_wen_o     = wen_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_wstrb_o   = wstrb_q;
  assign imem_rvalid_o = irvalid_q;
  assign imem_rdata_o  = irdata_q;
  assign dmem_rvalid_o = drvalid_q;
  assign dmem_rdata_o  = drdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level model of the arbiter, directed scenarios then random traffic.
module tb_mem_arbiter;
  localparam int MAXD = 2;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_i, imem_gnt_o, imem_rvalid_o;
  logic [31:0] imem_addr_i, imem_rdata_o;
  logic        dmem_req_i, dmem_wen_i, dmem_gnt_o, dmem_rvalid_o;
  logic [31:0] dmem_addr_i, dmem_wdata_i, dmem_rdata_o;
  logic [3:0]  dmem_wstrb_i;
  logic        mem_req_o, mem_wen_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wstrb_o;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_wen_i(dmem_wen_i), .dmem_addr_i(dmem_addr_i),
    .dmem_wdata_i(dmem_wdata_i), .dmem_wstrb_i(dmem_wstrb_i), .dmem_gnt_o(dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          d;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  int          total = 0, passed = 0;
  txn_t        pend[$];
  int          streak = 0;
  bit          exp_iv = 0, exp_dv = 0, eg_i, eg_d, ia = 0, da = 0;
  logic [31:0] exp_ird, exp_drd;
  logic        s_ig, s_dg, s_mreq, s_iv, s_dv, s_wen;
  logic [31:0] s_ird, s_drd, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [5:0]  gseq;
  int          ng, nst, nv;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
  endtask

  task automatic sample_and_check();
    bit busy;
    txn_t t;
    busy = pend.size() != 0;
    eg_d = !busy && dmem_req_i && !(imem_req_i && streak >= MAXD);
    eg_i = !busy && imem_req_i && !eg_d;
    s_ig = imem_gnt_o; s_dg = dmem_gnt_o; s_mreq = mem_req_o; s_wen = mem_wen_o;
    s_iv = imem_rvalid_o; s_dv = dmem_rvalid_o; s_ird = imem_rdata_o; s_drd = dmem_rdata_o;
    s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_wstrb = mem_wstrb_o;
    chk("imem_gnt", imem_gnt_o, eg_i);
    chk("dmem_gnt", dmem_gnt_o, eg_d);
    chk("mem_req", mem_req_o, busy);
    if (busy) begin
      t = pend[0];
      chk("mem_addr", mem_addr_o, t.addr);
      chk("mem_wen", mem_wen_o, t.wen);
      if (t.d) begin
        chk("mem_wdata", mem_wdata_o, t.wdata);
        chk("mem_wstrb", mem_wstrb_o, t.wstrb);
      end
    end
    chk("imem_rvalid", imem_rvalid_o, exp_iv);
    if (exp_iv) chk("imem_rdata", imem_rdata_o, exp_ird);
    chk("dmem_rvalid", dmem_rvalid_o, exp_dv);
    if (exp_dv) chk("dmem_rdata", dmem_rdata_o, exp_drd);
  endtask

  // what the coming clock edge must do, from the arbitration rules
  task automatic advance();
    txn_t t;
    exp_iv = 0;
    exp_dv = 0;
    if (pend.size() != 0 && mem_ready_i) begin
      t = pend.pop_front();
      if (t.d) begin exp_dv = 1; exp_drd = t.wen ? 32'h0 : mem_rdata_i; end
      else begin exp_iv = 1; exp_ird = mem_rdata_i; end
    end
    if (eg_i) begin
      pend.push_back('{d: 1'b0, wen: 1'b0, addr: imem_addr_i, wdata: 32'h0, wstrb: 4'h0});
      streak = 0;
      ia = 0;
    end
    if (eg_d) begin
      pend.push_back('{d: 1'b1, wen: dmem_wen_i, addr: dmem_addr_i, wdata: dmem_wdata_i, wstrb: dmem_wstrb_i});
      streak = imem_req_i ? (streak < MAXD ? streak + 1 : MAXD) : 0;
      da = 0;
    end
  endtask

  task automatic step();
    #5;
    sample_and_check();
    advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic async_reset();
    #2 rst_i = 1'b1;
    #1;
    chk("rst_imem_gnt", imem_gnt_o, 0);
    chk("rst_dmem_gnt", dmem_gnt_o, 0);
    chk("rst_imem_rvalid", imem_rvalid_o, 0);
    chk("rst_dmem_rvalid", dmem_rvalid_o, 0);
    chk("rst_imem_rdata", imem_rdata_o, 0);
    chk("rst_dmem_rdata", dmem_rdata_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_wen", mem_wen_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_mem_wstrb", mem_wstrb_o, 0);
    pend.delete();
    streak = 0; exp_iv = 0; exp_dv = 0; ia = 0; da = 0;
    imem_req_i = 0; dmem_req_i = 0; mem_ready_i = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 0; imem_req_i = 0; imem_addr_i = 0; dmem_req_i = 0; dmem_wen_i = 0;
    dmem_addr_i = 0; dmem_wdata_i = 0; dmem_wstrb_i = 0; mem_ready_i = 0; mem_rdata_i = 0;
    @(posedge clk_i); #1;
    async_reset();
    // fetch only
    imem_req_i = 1; imem_addr_i = 32'h100; step();
    chk("fetch_gnt", s_ig, 1);
    imem_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h13; step();
    chk("fetch_mem_req", s_mreq, 1);
    chk("fetch_mem_addr", s_addr, 32'h100);
    mem_ready_i = 0; step();
    chk("fetch_rvalid", s_iv, 1);
    chk("fetch_rdata", s_ird, 32'h13);
    // simultaneous requests: data first, fetch granted in the rvalid cycle
    imem_req_i = 1; imem_addr_i = 32'h104; dmem_req_i = 1; dmem_wen_i = 0; dmem_addr_i = 32'h2000; step();
    chk("simul_dgnt", s_dg, 1);
    chk("simul_ignt_low", s_ig, 0);
    dmem_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'hDEADBEEF; step();
    chk("simul_busy_ignt", s_ig, 0);
    mem_ready_i = 0; step();
    chk("simul_drvalid", s_dv, 1);
    chk("simul_drdata", s_drd, 32'hDEADBEEF);
    chk("simul_ignt_next", s_ig, 1);
    imem_req_i = 0; mem_ready_i = 1; step();
    mem_ready_i = 0; step();
    // starvation bound
    imem_req_i = 1; dmem_req_i = 1; mem_ready_i = 1; gseq = 0; ng = 0;
    repeat (12) begin
      step();
      if (s_dg || s_ig) begin gseq = {gseq[4:0], s_dg}; ng++; end
    end
    chk("starve_order", gseq, 6'b110110);
    chk("starve_count", ng, 6);
    imem_req_i = 0; dmem_req_i = 0; mem_ready_i = 0; step();
    // store with delayed ready
    dmem_req_i = 1; dmem_wen_i = 1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'hCAFEF00D; dmem_wstrb_i = 4'b0011; step();
    chk("store_gnt", s_dg, 1);
    dmem_req_i = 0; dmem_wen_i = 0; dmem_addr_i = 0; dmem_wdata_i = 0; dmem_wstrb_i = 0; nst = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready_i = (i == 3);
      step();
      if (s_mreq && s_wen && s_addr == 32'h40 && s_wdata == 32'hCAFEF00D && s_wstrb == 4'b0011) nst++;
    end
    chk("store_stable", nst, 4);
    mem_ready_i = 0; step();
    chk("store_rvalid", s_dv, 1);
    chk("store_rdata", s_drd, 0);
    step();
    chk("store_rvalid_once", s_dv, 0);
    // reset during a data transaction
    dmem_req_i = 1; dmem_wen_i = 0; dmem_addr_i = 32'h80; step();
    chk("abort_gnt", s_dg, 1);
    dmem_req_i = 0; step();
    chk("abort_busy", s_mreq, 1);
    async_reset();
    nv = 0;
    repeat (3) begin mem_ready_i = 1; step(); nv += int'(s_dv); end
    chk("abort_no_rvalid", nv, 0);
    mem_ready_i = 0; imem_req_i = 1; imem_addr_i = 32'h200; step();
    chk("abort_fetch_gnt", s_ig, 1);
    imem_req_i = 0; mem_ready_i = 1; mem_rdata_i = 32'h55; step();
    mem_ready_i = 0; step();
    chk("abort_fetch_rvalid", s_iv, 1);
    chk("abort_fetch_rdata", s_ird, 32'h55);
    // spurious ready in IDLE
    mem_ready_i = 1; mem_rdata_i = 32'h77; step(); step();
    chk("spur_iv", s_iv, 0);
    chk("spur_dv", s_dv, 0);
    chk("spur_mreq", s_mreq, 0);
    mem_ready_i = 0; imem_req_i = 1; imem_addr_i = 32'h300; step();
    chk("spur_fetch_gnt", s_ig, 1);
    imem_req_i = 0; mem_ready_i = 1; step();
    mem_ready_i = 0; step();
    chk("spur_fetch_rdata", s_ird, 32'h77);
    // requests withdrawn before any edge sees them
    imem_req_i = 1; dmem_req_i = 1; #2; imem_req_i = 0; dmem_req_i = 0; step();
    chk("drop_ignt", s_ig, 0);
    chk("drop_dgnt", s_dg, 0);
    step();
    chk("drop_mreq", s_mreq, 0);
    // random traffic
    ia = 0; da = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin async_reset(); continue; end
      if (!ia && $urandom_range(0, 2) == 0) begin ia = 1; imem_addr_i = $urandom; end
      if (!da && $urandom_range(0, 2) == 0) begin
        da = 1; dmem_wen_i = 1'($urandom_range(0, 1)); dmem_addr_i = $urandom;
        dmem_wdata_i = $urandom; dmem_wstrb_i = 4'($urandom_range(0, 15));
      end
      imem_req_i = ia; dmem_req_i = da;
      mem_ready_i = $urandom_range(0, 2) == 0;
      mem_rdata_i = $urandom;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
